// File: rtl/mem_target_pkg.sv
// rtl/mem_target_pkg.sv - shared encodings for the mem_target bus responder
package mem_target_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef enum logic [1:0] {NONE, OP, ADDR, ACCESS} fault_t;

    // Flag order is {op, addr, access}; at most one bit is ever set.
    function automatic logic [2:0] fault_flags(input fault_t f);
        return {f == OP, f == ADDR, f == ACCESS};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and load extraction/extension
module mem_lane_align
    import mem_target_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[8*i_offset +: 8];
    assign w_half = i_offset[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_be    = 4'b0000;
        o_wword = 32'h0;
        o_rdata = 32'h0;
        case (i_size)
            SIZE_BYTE: begin
                o_be    = 4'b0001 << i_offset;
                o_wword = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_be    = i_offset[1] ? 4'b1100 : 4'b0011;
                o_wword = {2{i_wdata[15:0]}};
                o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
            end
            SIZE_WORD: begin
                o_be    = 4'b1111;
                o_wword = i_wdata;
                o_rdata = i_rword;
            end
            default: begin
                o_be    = 4'b0000;
                o_wword = 32'h0;
                o_rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_target.sv
// rtl/mem_target.sv - single-outstanding load/store responder with wait states, ROM region and fault checks
module mem_target
    import mem_target_pkg::*;
#(
    parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
    parameter int          MEM_SIZE_BYTES = 4096,
    parameter int          ROM_SIZE_BYTES = 1024,
    parameter int          WAIT_STATES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_unsigned,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_op_fault,
    output logic        resp_addr_fault,
    output logic        resp_access_fault
);

    localparam int AW = $clog2(MEM_SIZE_BYTES);

    // 33-bit offset so an address below MEM_BASE or near the top of the space cannot alias in range.
    function automatic fault_t eval_fault(input logic w, input logic [1:0] sz, input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, MEM_BASE};
        if (sz == SIZE_ILLEGAL) return OP;
        if ((sz == SIZE_HALF && a[0]) || (sz == SIZE_WORD && a[1:0] != 2'b00)) return ADDR;
        if (off >= 33'(MEM_SIZE_BYTES)) return ACCESS;
        if (w && off < 33'(ROM_SIZE_BYTES)) return ACCESS;
        return NONE;
    endfunction

    state_t      r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic [2:0]  r_flags;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [MEM_SIZE_BYTES/4];

    fault_t      w_fault;
    logic [AW-1:0] w_off;
    logic [AW-3:0] w_idx;
    logic [31:0] w_rword;
    logic [3:0]  w_be;
    logic [31:0] w_wword;
    logic [31:0] w_rdata;
    logic        w_do_write;

    assign w_fault    = eval_fault(req_write, req_size, req_addr);
    assign w_off      = AW'(r_addr - MEM_BASE);
    assign w_idx      = w_off[AW-1:2];
    assign w_rword    = r_mem[w_idx];
    assign w_do_write = !reset && r_state == WAIT && r_cnt == 4'd0 && r_write;

    mem_lane_align u_align (
        .i_size     (r_size),
        .i_offset   (w_off[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_flags      <= 3'b000;
            r_cnt        <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_unsigned  <= req_unsigned;
                        r_size      <= req_size;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_fault != NONE) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 32'h0;
                            r_flags      <= fault_flags(w_fault);
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_write ? 32'h0 : w_rdata;
                        r_flags      <= 3'b000;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready         = r_req_ready;
    assign resp_valid        = r_resp_valid;
    assign resp_rdata        = r_resp_rdata;
    assign resp_op_fault     = r_flags[2];
    assign resp_addr_fault   = r_flags[1];
    assign resp_access_fault = r_flags[0];

endmodule

// File: tb/tb_mem_target.sv
// tb/tb_mem_target.sv - randomized self-checking bench for mem_target against a byte-array model
module tb_mem_target;

    localparam int          WS   = 2;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MSZ  = 4096;
    localparam int          RSZ  = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_op_fault;
    logic        resp_addr_fault;
    logic        resp_access_fault;

    mem_target #(
        .MEM_BASE(BASE), .MEM_SIZE_BYTES(MSZ), .ROM_SIZE_BYTES(RSZ), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_unsigned(req_unsigned), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_op_fault(resp_op_fault), .resp_addr_fault(resp_addr_fault),
        .resp_access_fault(resp_access_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  flags;
        int          lat;
        bit          known;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mdata [MSZ];
    bit          mknown [MSZ];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] last_rdata;
    logic [2:0]  last_flags;
    int          last_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: decide fault from the rules, then move bytes in a flat byte array.
    function automatic exp_t model(input logic w, input logic u, input logic [1:0] sz,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t   e;
        longint off;
        longint val;
        int     n;
        off = longint'(a) - longint'(BASE);
        e.rdata = 32'h0;
        e.flags = 3'b000;
        e.known = 1'b1;
        if (sz == 2'b11) e.flags = 3'b100;
        else if ((sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0)) e.flags = 3'b010;
        else if (off < 0 || off >= MSZ) e.flags = 3'b001;
        else if (w && off < RSZ) e.flags = 3'b001;
        e.lat = (e.flags != 3'b000) ? 1 : WS + 2;
        if (e.flags == 3'b000) begin
            n = 1 << sz;
            if (w) begin
                for (int i = 0; i < n; i++) begin
                    mdata[int'(off) + i]  = 8'((wd >> (8 * i)) & 32'hFF);
                    mknown[int'(off) + i] = 1'b1;
                end
            end else begin
                val = 0;
                for (int i = 0; i < n; i++) begin
                    val = val | (longint'(mdata[int'(off) + i]) << (8 * i));
                    if (!mknown[int'(off) + i]) e.known = 1'b0;
                end
                if (!u && n < 4 && ((val >> (8 * n - 1)) & 1) == 1) val = val | (-64'sd1 << (8 * n));
                e.rdata = val[31:0];
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp actual=1 required=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("flags", {resp_op_fault, resp_addr_fault, resp_access_fault}, e.flags);
                chk("latency", cyc - acc_cyc + 1, e.lat);
                if (e.known) chk("rdata", resp_rdata, e.rdata);
            end
        end
    end

    task automatic do_req(input logic w, input logic u, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", req_ready, 1'b1);
        req_valid = 1'b1; req_write = w; req_unsigned = u; req_size = sz; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        exp_q.push_back(model(w, u, sz, a, wd));
        if (!hold) req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (hold && !resp_valid) begin
                req_write = 1'($urandom); req_unsigned = 1'($urandom); req_size = 2'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
        end while (!resp_valid && n < 40);
        chk("resp_seen", resp_valid, 1'b1);
        last_rdata = resp_rdata;
        last_flags = {resp_op_fault, resp_addr_fault, resp_access_fault};
        last_lat   = cyc - acc_cyc + 1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_unsigned = 1'b0;
        req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < MSZ; i++) mknown[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_flags", {resp_op_fault, resp_addr_fault, resp_access_fault}, 3'b000);
        reset = 1'b0;
        @(negedge clk);

        do_req(1, 0, 2'b10, 32'h400, 32'hDEADBEEF, 0);
        chk("st_word_flags", last_flags, 3'b000);
        chk("st_word_rdata", last_rdata, 32'h0);
        chk("st_word_lat", last_lat, 4);
        do_req(0, 0, 2'b10, 32'h400, 32'h0, 0);
        chk("ld_word", last_rdata, 32'hDEADBEEF);
        chk("ld_word_lat", last_lat, 4);
        do_req(0, 0, 2'b00, 32'h403, 32'h0, 0);
        chk("ld_byte_s", last_rdata, 32'hFFFFFFDE);
        do_req(0, 1, 2'b00, 32'h403, 32'h0, 0);
        chk("ld_byte_u", last_rdata, 32'h000000DE);
        do_req(0, 0, 2'b01, 32'h402, 32'h0, 0);
        chk("ld_half_s", last_rdata, 32'hFFFFDEAD);
        do_req(1, 0, 2'b00, 32'h401, 32'h11, 0);
        do_req(0, 0, 2'b10, 32'h400, 32'h0, 0);
        chk("ld_after_byte_st", last_rdata, 32'hDEAD11EF);

        do_req(0, 0, 2'b11, 32'h3, 32'h0, 0);
        chk("op_flags", last_flags, 3'b100);
        chk("op_lat", last_lat, 1);
        chk("op_rdata", last_rdata, 32'h0);
        do_req(0, 0, 2'b10, 32'h402, 32'h0, 0);
        chk("addr_flags", last_flags, 3'b010);
        do_req(0, 0, 2'b10, 32'h1000, 32'h0, 0);
        chk("range_flags", last_flags, 3'b001);
        do_req(1, 0, 2'b10, 32'h10, 32'hCAFEF00D, 0);
        chk("rom_flags", last_flags, 3'b001);
        chk("rom_lat", last_lat, 1);
        do_req(0, 0, 2'b10, 32'hFFFF_FFFC, 32'h0, 0);
        chk("wrap_flags", last_flags, 3'b001);

        // Back-to-back with req_valid never dropping and garbage on the bus while busy.
        for (int i = 0; i < 6; i++)
            do_req(i % 2 == 0, 0, 2'b10, 32'h404 + 32'(4 * (i / 2)), 32'h1000_0001 * 32'(i + 1), 1);
        req_valid = 1'b0;
        do_req(0, 0, 2'b10, 32'h400, 32'h0, 0);
        chk("ld_after_hold", last_rdata, 32'hDEAD11EF);

        // Reset in the middle of WAIT of a store: nothing must commit or respond.
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h400; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1'b1);
        chk("post_rst_valid", resp_valid, 1'b0);
        repeat (6) @(negedge clk);
        do_req(0, 0, 2'b10, 32'h400, 32'h0, 0);
        chk("ld_after_rst", last_rdata, 32'hDEAD11EF);

        for (int i = 0; i < 16; i++) do_req(1, 0, 2'b10, 32'h400 + 32'(4 * i), $urandom, 0);
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          r;
            r  = int'($urandom_range(0, 9));
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (r <= 6)      a = 32'h400 + 32'($urandom_range(0, 63));
            else if (r == 7) a = 32'($urandom_range(0, 1023));
            else if (r == 8) a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            else             a = 32'h0FFC + 32'($urandom_range(0, 7));
            do_req(1'($urandom), 1'($urandom), sz, a, $urandom, 1'($urandom));
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
